stream_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives the team's behavioural memory array (sync write, registered 1-cycle read) and turns it into a valid/ready stream FIFO.
- Owns the write/read pointers, the occupancy count and the handshakes.
- Feeds the array's write_data/write_addr/write_en/read_addr and consumes its read_data.
- Sits between a producer stream and a consumer stream. Capacity is DEPTH words.

---
 rtl/stream_fifo_ctrl.sv | 87 ++++++++
 tb/tb_stream_fifo_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo_ctrl.sv
// Valid/ready stream FIFO controller around an external sync-write, registered-read memory array.
// Define FIFO_LEVEL_EN to add the level and almost_full status outputs.
module stream_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [WIDTH-1:0]           mem_write_data,
    output logic [$clog2(DEPTH)-1:0]   mem_write_addr,
    output logic                       mem_write_en,
    output logic [$clog2(DEPTH)-1:0]   mem_read_addr,
    input  logic [WIDTH-1:0]           mem_read_data
`ifdef FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full
`endif
);

    localparam int ADDR = $clog2(DEPTH);
    localparam logic [ADDR:0] Full = (ADDR+1)'(DEPTH);

    logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR:0]   count_q, count_d;
    logic            out_valid_q, out_valid_d;
    logic [ADDR:0]   remain;
    logic            push, pop;

    assign in_ready = !rst && (count_q != Full);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    assign out_valid      = out_valid_q;
    assign out_data       = mem_read_data;
    assign mem_write_data = in_data;
    assign mem_write_addr = wr_ptr_q;
    assign mem_write_en   = push;

    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + ADDR'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + ADDR'(1) : rd_ptr_q;
        count_d       = count_q + {{ADDR{1'b0}}, push} - {{ADDR{1'b0}}, pop};
        // Only words already in the array count, so a same-cycle push is not yet visible.
        remain        = count_q - {{ADDR{1'b0}}, pop};
        out_valid_d   = (remain != '0);
        // Next head address, so the registered read presents it one edge later.
        mem_read_addr = rd_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef FIFO_LEVEL_EN
    logic almost_full_q;

    assign level       = count_q;
    assign almost_full = almost_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_d >= Full - (ADDR+1)'(2));
        end
    end
`endif

endmodule

// File: tb/tb_stream_fifo_ctrl.sv
// Self-checking bench for stream_fifo_ctrl: behavioural memory array plus a queue-based model.
module tb_stream_fifo_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int ADDR  = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] mem_write_data;
    logic [ADDR-1:0]  mem_write_addr;
    logic             mem_write_en;
    logic [ADDR-1:0]  mem_read_addr;
    logic [WIDTH-1:0] mem_read_data;
`ifdef FIFO_LEVEL_EN
    logic [ADDR:0]    level;
    logic             almost_full;
`endif

    always #5 clk = ~clk;

    stream_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .mem_write_data (mem_write_data),
        .mem_write_addr (mem_write_addr),
        .mem_write_en   (mem_write_en),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data)
`ifdef FIFO_LEVEL_EN
        ,
        .level          (level),
        .almost_full    (almost_full)
`endif
    );

    // Behavioural memory array: synchronous write, registered read (old data on collision).
    logic [WIDTH-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem_read_data = '0;
    end
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
        mem_read_data <= mem[mem_read_addr];
    end

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] popped[$];
    logic [WIDTH-1:0] pushed[$];
    bit               exp_valid;
    bit               exp_af;
    int               wr_idx;
    int               errors = 0;
    int               checks = 0;

    // One cycle: inputs already driven; check outputs, then advance model across the edge.
    task automatic step();
        bit exp_ready, push, pop, nv;
        int sz;
        #1;
        exp_ready = !rst && (q.size() != DEPTH);
        push = in_valid && exp_ready;
        pop  = exp_valid && out_ready;
        checks++;
        if (in_ready !== exp_ready) begin
            errors++; $display("FAIL in_ready: got %b want %b", in_ready, exp_ready);
        end
        checks++;
        if (out_valid !== exp_valid) begin
            errors++; $display("FAIL out_valid: got %b want %b", out_valid, exp_valid);
        end
        checks++;
        if (mem_write_en !== push) begin
            errors++; $display("FAIL mem_write_en: got %b want %b", mem_write_en, push);
        end
        if (push) begin
            checks++;
            if (mem_write_addr !== ADDR'(wr_idx) || mem_write_data !== in_data) begin
                errors++;
                $display("FAIL write_port: got addr %0d data %h want addr %0d data %h",
                         mem_write_addr, mem_write_data, wr_idx, in_data);
            end
        end
        if (exp_valid) begin
            checks++;
            if (out_data !== q[0]) begin
                errors++; $display("FAIL out_data: got %h want %h", out_data, q[0]);
            end
        end
`ifdef FIFO_LEVEL_EN
        checks++;
        if (level !== (ADDR+1)'(q.size()) || almost_full !== exp_af) begin
            errors++;
            $display("FAIL level_af: got level %0d af %b want level %0d af %b",
                     level, almost_full, q.size(), exp_af);
        end
`endif
        @(posedge clk);
        if (rst) begin
            q.delete();
            exp_valid = 0;
            exp_af = 0;
            wr_idx = 0;
        end else begin
            sz = q.size();
            nv = (sz - int'(pop)) != 0;
            if (pop) popped.push_back(q.pop_front());
            if (push) begin
                q.push_back(in_data);
                pushed.push_back(in_data);
                wr_idx = (wr_idx + 1) % DEPTH;
            end
            exp_valid = nv;
            exp_af = (q.size() >= DEPTH - 2);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 0;
        out_ready = 1;
        while ((q.size() != 0 || exp_valid) && n < 4 * DEPTH) begin
            step();
            n++;
        end
        checks++;
        if (q.size() != 0 || exp_valid) begin
            errors++; $display("FAIL drain_timeout: got %0d left want 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; out_ready = 0; in_data = '0;
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got rdy %b vld %b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        bit v2, v3;
        popped.delete();
        out_ready = 1;
        in_valid = 1; in_data = 8'hA5;
        step();
        in_valid = 0;
        step();
        #1 v2 = out_valid;
        step();
        #1 v3 = out_valid;
        step();
        checks++;
        if (v2 !== 1'b1 || v3 !== 1'b0 || popped.size() != 1 || popped[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single: got vld2 %b vld3 %b npop %0d want 1 0 1 (a5)",
                     v2, v3, popped.size());
        end
    endtask

    task automatic test_full();
        popped.delete();
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_data = WIDTH'(i);
            step();
        end
        in_data = 8'hFF;
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready: got %b want 0", in_ready);
        end
        drain();
        checks++;
        if (popped.size() != DEPTH) begin
            errors++; $display("FAIL full_drain_len: got %0d want %0d", popped.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (popped[i] !== WIDTH'(i)) begin
                    errors++; $display("FAIL full_order[%0d]: got %h want %h", i, popped[i], i);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1; in_data = WIDTH'($urandom);
            step();
        end
        in_valid = 1; in_data = 8'h77;
        for (int i = 0; i < 2; i++) step();
        out_ready = 1;
        step();
        out_ready = 0;
        step();
        step();
        checks++;
        if (q.size() != DEPTH || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_pulse: got rdy %b want 0", in_ready);
        end
        drain();
    endtask

    task automatic test_stream();
        int sent = 0;
        int guard = 0;
        popped.delete(); pushed.delete();
        in_valid = 1;
        while (sent < 40 && guard < 400) begin
            in_data = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (in_ready) sent++;
            step();
            guard++;
        end
        drain();
        checks++;
        if (popped.size() != 40 || popped != pushed) begin
            errors++; $display("FAIL stream_order: got %0d words want 40 in order", popped.size());
        end
    endtask

    task automatic test_reset_mid();
        popped.delete();
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = WIDTH'($urandom);
            step();
        end
        rst = 1;
        step();
        rst = 0; in_valid = 0;
        step();
        in_valid = 1; in_data = 8'h3C;
        step();
        drain();
        checks++;
        if (popped.size() == 0 || popped[0] !== 8'h3C) begin
            errors++;
            $display("FAIL reset_mid_first: got %0d words (first %h) want 3c",
                     popped.size(), popped.size() ? popped[0] : 8'h00);
        end
    endtask

    initial begin
        exp_valid = 0; exp_af = 0; wr_idx = 0;
        rst = 1; in_valid = 0; out_ready = 0; in_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_full();
        test_full_pop();
        test_stream();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
